alu_mc_pipe: RTL and testbench

//  Multi-cycle, handshaked successor to the single-cycle RV32I ALU for the pipelined core's EX stage.
//  - Base RV32I ops complete in 1 cycle; RV32M mul/div ops run on an iterative shift-add/restoring unit.
//  - Width-parametrised; carries a tag (e.g. rd index) alongside each result.
//  - Holds one operation in flight, with valid/ready flow control on both sides and a kill input for flush.

---
 rtl/alu_pkg.sv | 45 ++++
 rtl/alu_muldiv_iter.sv | 134 +++++++++++++
 rtl/alu_mc_pipe.sv | 140 ++++++++++++++
 tb/tb_alu_mc_pipe.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_pkg                                                                    |
// | Opcode and FSM state types plus shared constants for alu_mc_pipe.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package alu_pkg;

  typedef enum logic [4:0] {
    OP_ADD    = 5'd0,
    OP_SUB    = 5'd1,
    OP_SLL    = 5'd2,
    OP_SLT    = 5'd3,
    OP_SLTU   = 5'd4,
    OP_XOR    = 5'd5,
    OP_SRL    = 5'd6,
    OP_SRA    = 5'd7,
    OP_OR     = 5'd8,
    OP_AND    = 5'd9,
    OP_MUL    = 5'd10,
    OP_MULH   = 5'd11,
    OP_MULHSU = 5'd12,
    OP_MULHU  = 5'd13,
    OP_DIV    = 5'd14,
    OP_DIVU   = 5'd15,
    OP_REM    = 5'd16,
    OP_REMU   = 5'd17
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Wide enough for any supported WIDTH; users slice [WIDTH-1:0].
  localparam logic [63:0] DIV_ALL_ONES  = '1;
  localparam logic [4:0]  OP_LAST_LEGAL = 5'd17;

  function automatic logic is_muldiv(input logic [4:0] op);
    return (op >= 5'(OP_MUL)) && (op <= OP_LAST_LEGAL);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_muldiv_iter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_muldiv_iter                                                            |
// | WIDTH-step shift-add multiplier / restoring divider with sign fix-up.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             abort_i,
  input  alu_op_e          op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] res_o
);

  localparam int c_cnt_w = $clog2(WIDTH);
  localparam logic [c_cnt_w-1:0] c_last_iter = c_cnt_w'(WIDTH - 1);

  logic               r_active;
  logic [c_cnt_w-1:0] r_cnt;
  alu_op_e            r_op;
  logic               r_neg;
  logic               r_divz;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_md;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_a_sgn;
  logic               w_b_sgn;
  logic               w_is_div;
  logic               w_r_is_div;
  logic               w_neg;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_sh;
  logic [WIDTH:0]     w_diff;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_fix;

  always_comb begin
    w_a_sgn = 1'b0;
    w_b_sgn = 1'b0;
    case (op_i)
      OP_MULH, OP_DIV, OP_REM: begin
        w_a_sgn = a_i[WIDTH-1];
        w_b_sgn = b_i[WIDTH-1];
      end
      OP_MULHSU: w_a_sgn = a_i[WIDTH-1];
      default: ;
    endcase
  end

  assign w_is_div   = op_i inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  assign w_r_is_div = r_op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  assign w_a_mag    = w_a_sgn ? (~a_i + 1'b1) : a_i;
  assign w_b_mag    = w_b_sgn ? (~b_i + 1'b1) : b_i;
  // Remainder takes the dividend's sign; everything else the product/quotient sign.
  assign w_neg      = (op_i inside {OP_REM, OP_REMU}) ? w_a_sgn : (w_a_sgn ^ w_b_sgn);

  assign w_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_md} : {(WIDTH+1){1'b0}});
  assign w_sh   = {r_hi, r_lo[WIDTH-1]};
  assign w_diff = w_sh - {1'b0, r_md};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_active <= 1'b0;
      r_cnt    <= '0;
      r_op     <= OP_ADD;
      r_neg    <= 1'b0;
      r_divz   <= 1'b0;
      r_a      <= '0;
      r_md     <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else if (abort_i) begin
      r_active <= 1'b0;
    end else if (start_i) begin
      r_active <= 1'b1;
      r_cnt    <= '0;
      r_op     <= op_i;
      r_neg    <= w_neg;
      r_divz   <= (b_i == '0);
      r_a      <= a_i;
      r_hi     <= '0;
      r_md     <= w_is_div ? w_b_mag : w_a_mag;
      r_lo     <= w_is_div ? w_a_mag : w_b_mag;
    end else if (r_active) begin
      r_cnt <= r_cnt + 1'b1;
      if (r_cnt == c_last_iter) r_active <= 1'b0;
      if (w_r_is_div) begin
        if (!w_diff[WIDTH]) begin
          r_hi <= w_diff[WIDTH-1:0];
          r_lo <= {r_lo[WIDTH-2:0], 1'b1};
        end else begin
          r_hi <= w_sh[WIDTH-1:0];
          r_lo <= {r_lo[WIDTH-2:0], 1'b0};
        end
      end else begin
        r_hi <= w_sum[WIDTH:1];
        r_lo <= {w_sum[0], r_lo[WIDTH-1:1]};
      end
    end
  end

  // Asserted during the final iteration; res_o is final after that edge.
  assign done_o = r_active & (r_cnt == c_last_iter);

  assign w_prod     = {r_hi, r_lo};
  assign w_prod_fix = r_neg ? (~w_prod + 1'b1) : w_prod;

  always_comb begin
    res_o = '0;
    case (r_op)
      OP_MUL:                       res_o = r_lo;
      OP_MULH, OP_MULHSU, OP_MULHU: res_o = w_prod_fix[2*WIDTH-1:WIDTH];
      OP_DIV, OP_DIVU:
        res_o = r_divz ? DIV_ALL_ONES[WIDTH-1:0] : (r_neg ? (~r_lo + 1'b1) : r_lo);
      OP_REM, OP_REMU:
        res_o = r_divz ? r_a : (r_neg ? (~r_hi + 1'b1) : r_hi);
      default: res_o = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu_mc_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_mc_pipe                                                                |
// | Handshaked multi-cycle RV32IM ALU; M ops present when ALU_MULDIV_EN set.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module alu_mc_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [4:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic             kill_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] res_o,
  output logic [TAG_W-1:0] tag_o,
  output logic             illegal_o,
  output logic             busy_o
);

  localparam int c_sh_w = $clog2(WIDTH);

  state_e            r_state;
  state_e            w_state_nxt;
  alu_op_e           w_op;
  logic              w_accept;
  logic              w_is_m;
  logic              w_illegal;
  logic [c_sh_w-1:0] w_shamt;
  logic [WIDTH-1:0]  w_base_res;
  logic [WIDTH-1:0]  r_res;
  logic [TAG_W-1:0]  r_tag;
  logic              r_illegal;

  assign w_op       = alu_op_e'(op_i);
  assign w_shamt    = b_i[c_sh_w-1:0];
  assign in_ready_o = ~kill_i & ((r_state == IDLE) | ((r_state == DONE) & out_ready_i));
  assign w_accept   = in_valid_i & in_ready_o;

`ifdef ALU_MULDIV_EN
  assign w_is_m = is_muldiv(op_i);
`else
  assign w_is_m = 1'b0;
`endif
  assign w_illegal = ~w_is_m & (op_i > 5'(OP_AND));

  always_comb begin
    w_base_res = '0;
    case (w_op)
      OP_ADD:  w_base_res = a_i + b_i;
      OP_SUB:  w_base_res = a_i - b_i;
      OP_SLL:  w_base_res = a_i << w_shamt;
      OP_SLT:  w_base_res = {{(WIDTH-1){1'b0}}, $signed(a_i) < $signed(b_i)};
      OP_SLTU: w_base_res = {{(WIDTH-1){1'b0}}, a_i < b_i};
      OP_XOR:  w_base_res = a_i ^ b_i;
      OP_SRL:  w_base_res = a_i >> w_shamt;
      OP_SRA:  w_base_res = $signed(a_i) >>> w_shamt;
      OP_OR:   w_base_res = a_i | b_i;
      OP_AND:  w_base_res = a_i & b_i;
      default: w_base_res = '0;
    endcase
  end

`ifdef ALU_MULDIV_EN
  logic             w_m_done;
  logic [WIDTH-1:0] w_m_res;
  logic             r_from_m;

  alu_muldiv_iter #(
    .WIDTH (WIDTH)
  ) u_muldiv (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .start_i (w_accept & w_is_m),
    .abort_i (kill_i),
    .op_i    (w_op),
    .a_i     (a_i),
    .b_i     (b_i),
    .done_o  (w_m_done),
    .res_o   (w_m_res)
  );

  // The iterative unit holds its result registers until the next start.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)       r_from_m <= 1'b0;
    else if (kill_i)   r_from_m <= 1'b0;
    else if (w_accept) r_from_m <= w_is_m;
  end

  assign res_o = r_from_m ? w_m_res : r_res;
`else
  assign res_o = r_res;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (w_accept) w_state_nxt = w_is_m ? BUSY : DONE;
`ifdef ALU_MULDIV_EN
      BUSY: if (w_m_done) w_state_nxt = DONE;
`endif
      DONE: if (out_ready_i) w_state_nxt = w_accept ? (w_is_m ? BUSY : DONE) : IDLE;
      default: w_state_nxt = IDLE;
    endcase
    if (kill_i) w_state_nxt = IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_res     <= '0;
      r_tag     <= '0;
      r_illegal <= 1'b0;
    end else if (w_accept) begin
      r_tag     <= tag_i;
      r_illegal <= w_illegal;
      if (!w_is_m) r_res <= w_base_res;
    end
  end

  assign out_valid_o = (r_state == DONE);
  assign tag_o       = r_tag;
  assign illegal_o   = r_illegal;
  assign busy_o      = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alu_mc_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_alu_mc_pipe                                                             |
// | Random and directed stimulus against a transaction-level ALU model.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_alu_mc_pipe;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic [4:0]  tag;
  logic        kill;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] res;
  logic [4:0]  tag_out;
  logic        illegal;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected-output model: one result slot plus a countdown for the op in flight.
  logic        m_valid;
  logic        m_inflight;
  int          m_cnt;
  logic [31:0] m_res;
  logic [4:0]  m_tag;
  logic        m_ill;

  alu_mc_pipe #(.WIDTH(32), .TAG_W(5)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .op_i        (op),
    .a_i         (a),
    .b_i         (b),
    .tag_i       (tag),
    .kill_i      (kill),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .res_o       (res),
    .tag_o       (tag_out),
    .illegal_o   (illegal),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_op(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                                   output logic [31:0] r, output logic ill, output int lat);
    logic [63:0] p;
    longint      sx;
    longint      sy;
    logic [4:0]  sh;
    sh  = y[4:0];
    sx  = longint'($signed(x));
    sy  = longint'($signed(y));
    r   = 32'h0;
    ill = 1'b0;
    lat = 1;
    p   = 64'h0;
    case (o)
      OP_ADD:  r = x + y;
      OP_SUB:  r = x - y;
      OP_SLL:  r = x << sh;
      OP_SLT:  r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      OP_SLTU: r = (x < y) ? 32'd1 : 32'd0;
      OP_XOR:  r = x ^ y;
      OP_SRL:  r = x >> sh;
      OP_SRA:  r = $signed(x) >>> sh;
      OP_OR:   r = x | y;
      OP_AND:  r = x & y;
`ifdef ALU_MULDIV_EN
      OP_MUL:    begin p = {32'h0, x} * {32'h0, y}; r = p[31:0];  lat = 33; end
      OP_MULH:   begin p = sx * sy;                 r = p[63:32]; lat = 33; end
      OP_MULHSU: begin p = sx * longint'({32'h0, y}); r = p[63:32]; lat = 33; end
      OP_MULHU:  begin p = {32'h0, x} * {32'h0, y}; r = p[63:32]; lat = 33; end
      OP_DIV: begin
        lat = 33;
        if (y == 0) r = 32'hFFFF_FFFF;
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = 32'h8000_0000;
        else r = 32'(sx / sy);
      end
      OP_DIVU: begin lat = 33; r = (y == 0) ? 32'hFFFF_FFFF : x / y; end
      OP_REM: begin
        lat = 33;
        if (y == 0) r = x;
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = 32'h0;
        else r = 32'(sx % sy);
      end
      OP_REMU: begin lat = 33; r = (y == 0) ? x : x % y; end
`endif
      default: begin r = 32'h0; ill = 1'b1; end
    endcase
  endfunction

  task automatic model_reset();
    m_valid    = 1'b0;
    m_inflight = 1'b0;
    m_cnt      = 0;
    m_res      = 32'h0;
    m_tag      = 5'h0;
    m_ill      = 1'b0;
  endtask

  // One clock cycle: check registered outputs, drive inputs, check in_ready, advance model.
  task automatic step(input logic v, input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                      input logic [4:0] tg, input logic k, input logic ordy);
    logic [31:0] er;
    logic        ei;
    int          el;
    logic        exp_rdy;
    @(negedge clk);
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("busy", 32'(busy), 32'(m_valid | m_inflight));
    if (m_valid) begin
      chk("res", res, m_res);
      chk("tag", 32'(tag_out), 32'(m_tag));
      chk("illegal", 32'(illegal), 32'(m_ill));
    end
    in_valid  = v;
    op        = o;
    a         = x;
    b         = y;
    tag       = tg;
    kill      = k;
    out_ready = ordy;
    #1;
    exp_rdy = !k && (!(m_valid || m_inflight) || (m_valid && ordy));
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    if (k) begin
      m_valid    = 1'b0;
      m_inflight = 1'b0;
    end else begin
      if (m_valid && ordy) m_valid = 1'b0;
      if (m_inflight) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_inflight = 1'b0;
          m_valid    = 1'b1;
        end
      end
      if (v && exp_rdy) begin
        model_op(o, x, y, er, ei, el);
        m_res = er;
        m_ill = ei;
        m_tag = tg;
        if (el == 1) m_valid = 1'b1;
        else begin
          m_inflight = 1'b1;
          m_cnt      = el - 1;
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 5'd0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((m_valid || m_inflight) && n < 100) begin
      step(1'b0, 5'd0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1);
      n++;
    end
    chk("drain_bound", 32'(n >= 100), 32'h0);
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] corners [5];
    corners = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  logic [31:0] dir_op [10];
  logic [31:0] dir_a  [10];
  logic [31:0] dir_b  [10];

  initial begin
    logic [31:0] pr;
    logic        pi;
    int          pl;
    logic [4:0]  rop;

    // Hand-computed pins on the model itself.
    model_op(OP_ADD, 32'h7FFF_FFFF, 32'h1, pr, pi, pl);  chk("model_add", pr, 32'h8000_0000);
    model_op(OP_SRA, 32'h8000_0000, 32'h21, pr, pi, pl); chk("model_sra", pr, 32'hC000_0000);
    model_op(OP_SLL, 32'h0000_1234, 32'd32, pr, pi, pl); chk("model_sll", pr, 32'h0000_1234);
    model_op(5'd20, 32'h5, 32'h6, pr, pi, pl);           chk("model_ill", {pr[30:0], pi}, 32'h1);
`ifdef ALU_MULDIV_EN
    model_op(OP_MULH, 32'h8000_0000, 32'h8000_0000, pr, pi, pl); chk("model_mulh", pr, 32'h4000_0000);
    chk("model_mlat", 32'(pl), 32'd33);
    model_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, pr, pi, pl);  chk("model_divovf", pr, 32'h8000_0000);
    model_op(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, pr, pi, pl);  chk("model_removf", pr, 32'h0);
    model_op(OP_DIVU, 32'h5, 32'h0, pr, pi, pl);                 chk("model_divu0", pr, 32'hFFFF_FFFF);
    model_op(OP_REMU, 32'h5, 32'h0, pr, pi, pl);                 chk("model_remu0", pr, 32'h5);
`else
    model_op(OP_MUL, 32'h5, 32'h6, pr, pi, pl); chk("model_mul_ill", {pr[30:0], pi}, 32'h1);
    chk("model_mul_lat", 32'(pl), 32'd1);
`endif

    // Reset state.
    rst_ni = 1'b0; in_valid = 1'b0; op = 5'd0; a = 32'h0; b = 32'h0;
    tag = 5'd0; kill = 1'b0; out_ready = 1'b1;
    model_reset();
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_res", res, 32'h0);
    chk("rst_tag", 32'(tag_out), 32'h0);
    chk("rst_illegal", 32'(illegal), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    @(negedge clk);
    rst_ni = 1'b1;

    // Directed cases from the datasheet examples.
    dir_op = '{OP_ADD, OP_SRA, OP_SLL, OP_MULH, OP_DIV, OP_REM, OP_DIVU, OP_REMU, 32'd20, OP_MUL};
    dir_a  = '{32'h7FFF_FFFF, 32'h8000_0000, 32'h1234, 32'h8000_0000, 32'h8000_0000,
               32'h8000_0000, 32'h5, 32'h5, 32'h9, 32'hFFFF_FFFF};
    dir_b  = '{32'h1, 32'h21, 32'd32, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               32'h0, 32'h0, 32'h3, 32'h3};
    for (int i = 0; i < 10; i++) begin
      step(1'b1, dir_op[i][4:0], dir_a[i], dir_b[i], 5'(i + 3), 1'b0, 1'b1);
      drain();
    end

    // Backpressure then back-to-back release.
    step(1'b1, OP_ADD, 32'h1, 32'h2, 5'd7, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, OP_SUB, 32'h9, 32'h9, 5'd8, 1'b0, 1'b0);
    step(1'b1, OP_XOR, 32'hF0, 32'h0F, 5'd6, 1'b0, 1'b1);
    drain();

    // Flush while an M op iterates.
    step(1'b1, OP_MUL, 32'h1234, 32'h5678, 5'd11, 1'b0, 1'b1);
    idle(9);
    step(1'b0, 5'd0, 32'h0, 32'h0, 5'd0, 1'b1, 1'b1);
    idle(3);
    drain();

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      rop = ($urandom_range(0, 99) < 85) ? 5'($urandom_range(0, 17)) : 5'($urandom_range(18, 31));
      step($urandom_range(0, 99) < 60, rop, pick(), pick(), 5'($urandom),
           $urandom_range(0, 99) < 2, $urandom_range(0, 99) < 75);
    end
    drain();

    // Asynchronous reset in the middle of an operation.
    step(1'b1, OP_DIV, 32'd100, 32'd7, 5'd9, 1'b0, 1'b1);
    idle(5);
    #2;
    rst_ni   = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'h0);
    chk("arst_res", res, 32'h0);
    chk("arst_tag", 32'(tag_out), 32'h0);
    chk("arst_illegal", 32'(illegal), 32'h0);
    chk("arst_busy", 32'(busy), 32'h0);
    model_reset();
    @(negedge clk);
    rst_ni = 1'b1;
    idle(40);
    step(1'b1, OP_AND, 32'hFF00, 32'h0FF0, 5'd21, 1'b0, 1'b1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
